register_write_arbiter: RTL



---
 rtl/register_write_arbiter.sv | 115 +++++++++++
 1 files changed

// File: rtl/register_write_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources; round-robin by default, fixed priority when WRITE_ARB_FIXED_PRIORITY_EN is defined.
// Latency: exactly one cycle from an accepted request to write_enable/write_address/write_data.
// Backpressure: hold or reset forces req_ready to zero; the write port itself accepts every cycle, so nothing is buffered.
module register_write_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            hold,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            write_enable,
  output logic [ADDR_WIDTH-1:0]           write_address,
  output logic [DATA_WIDTH-1:0]           write_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                  w_gnt_vld;
  logic [PTR_W-1:0]      w_gnt_idx;
  logic [NUM_REQ-1:0]    w_gnt;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;

`ifdef WRITE_ARB_FIXED_PRIORITY_EN
  // Descending scan so the lowest valid index is the last one written.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (reset && !hold) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (req_valid[i]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = PTR_W'(i);
        end
      end
    end
  end
`else
  logic [PTR_W-1:0] r_ptr;

  // Scan ptr+NUM_REQ down to ptr+1; the last hit is the first valid after ptr.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (reset && !hold) begin
      for (int k = NUM_REQ; k >= 1; k--) begin
        idx = (int'(r_ptr) + k) % NUM_REQ;
        if (req_valid[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = PTR_W'(idx);
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ptr <= PTR_W'(NUM_REQ - 1);
    end else if (w_gnt_vld) begin
      r_ptr <= w_gnt_idx;
    end
  end
`endif

  always_comb begin
    w_gnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt[i] = w_gnt_vld && (w_gnt_idx == PTR_W'(i));
    end
  end

  assign req_ready = w_gnt;

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_address[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A write to register 0 is still accepted, but never reaches the register file.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_gnt_vld && (w_sel_addr != '0);
      if (w_gnt_vld) begin
        r_addr <= w_sel_addr;
        r_data <= w_sel_data;
      end
    end
  end

  assign write_enable  = r_we;
  assign write_address = r_addr;
  assign write_data    = r_data;

endmodule
